// File: rtl/keccak_pkg.sv
// Shared Keccak engine definitions: rate encodings, absorb FSM states
// and sizing constants for the absorb sequencing path.
package keccak_pkg;

  localparam int RATE_WIDTH = 11;
  localparam int MAX_RATE_BYTES = 168;
  localparam int BYTE_ABSORB_WIDTH = $clog2(MAX_RATE_BYTES + 1);
  localparam int STAGE_BYTES = 56;
  localparam int STAGE_CNT_WIDTH = $clog2(STAGE_BYTES + 1);

  localparam logic [RATE_WIDTH-1:0] RATE_1344 = 11'd1344;
  localparam logic [RATE_WIDTH-1:0] RATE_1152 = 11'd1152;
  localparam logic [RATE_WIDTH-1:0] RATE_1088 = 11'd1088;
  localparam logic [RATE_WIDTH-1:0] RATE_832  = 11'd832;
  localparam logic [RATE_WIDTH-1:0] RATE_576  = 11'd576;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PERM,
    ST_PAD,
    ST_DONE
  } absorb_state_e;

  function automatic logic rate_legal(
    input logic [RATE_WIDTH-1:0] r
  );
    return (r == RATE_1344) ||
           (r == RATE_1152) ||
           (r == RATE_1088) ||
           (r == RATE_832)  ||
           (r == RATE_576);
  endfunction

endpackage

// File: rtl/keccak_absorb_ctrl_if.sv
// Byte-keyed input stream into the absorb controller.
// Source drives valid/last/data/keep, sink answers with ready.
interface keccak_absorb_ctrl_if #(
  parameter int DWIDTH = 256
) ();

  localparam int KEEP_WIDTH = DWIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic                  last;
  logic [DWIDTH-1:0]     data;
  logic [KEEP_WIDTH-1:0] keep;

  modport master (
    output valid,
    output last,
    output data,
    output keep,
    input  ready
  );

  modport slave (
    input  valid,
    input  last,
    input  data,
    input  keep,
    output ready
  );

endinterface

// File: rtl/keccak_absorb_ctrl_lane_realign.sv
// Merges the staging buffer with an accepted beat, emits the bytes that
// fit the remaining rate space and shifts the rest back into the stage.
module lane_realign
  import keccak_pkg::*;
#(
  parameter int DWIDTH = 256,
  localparam int KEEP_WIDTH = DWIDTH / 8,
  localparam int SB = STAGE_BYTES * 8,
  localparam int CW = (STAGE_BYTES + KEEP_WIDTH) * 8,
  localparam int W = BYTE_ABSORB_WIDTH
) (
  input  logic [SB-1:0]              stage,
  input  logic [STAGE_CNT_WIDTH-1:0] stage_cnt,
  input  logic                       beat_en,
  input  logic [DWIDTH-1:0]          beat_data,
  input  logic [KEEP_WIDTH-1:0]      beat_keep,
  input  logic [W-1:0]               room,
  output logic [W-1:0]               take,
  output logic [DWIDTH-1:0]          msg,
  output logic [KEEP_WIDTH-1:0]      keep,
  output logic [SB-1:0]              stage_nxt,
  output logic [STAGE_CNT_WIDTH-1:0] stage_cnt_nxt
);

  logic [DWIDTH-1:0] beat_ext;
  logic [W-1:0]      beat_cnt;
  logic [W-1:0]      comb_cnt;
  logic [CW-1:0]     comb;
  logic [SB-1:0]     shifted;

  always_comb begin
    beat_ext = '0;
    beat_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (beat_en && beat_keep[i]) begin
        beat_ext[i*8 +: 8] = beat_data[i*8 +: 8];
        beat_cnt = beat_cnt + 1'b1;
      end
    end

    // a beat is only accepted with a lane-aligned stage
    comb = CW'(stage) |
      (CW'(beat_ext) << {stage_cnt[STAGE_CNT_WIDTH-1:3], 6'b0});
    comb_cnt = W'(stage_cnt) + beat_cnt;

    take = comb_cnt;
    if (room < take) take = room;
    if (take > W'(KEEP_WIDTH)) take = W'(KEEP_WIDTH);

    msg  = '0;
    keep = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (i < int'(take)) begin
        keep[i] = 1'b1;
        msg[i*8 +: 8] = comb[i*8 +: 8];
      end
    end

    // a partial-lane take always empties the stage, so lane shifts suffice
    shifted = SB'(comb >> {take[W-1:3], 6'b0});
    stage_cnt_nxt = STAGE_CNT_WIDTH'(comb_cnt - take);

    stage_nxt = '0;
    for (int i = 0; i < STAGE_BYTES; i++) begin
      if (i < int'(stage_cnt_nxt)) begin
        stage_nxt[i*8 +: 8] = shifted[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/keccak_absorb_ctrl.sv
// Absorb sequencer: feeds rate-sized blocks to absorb_unit, starts the
// permutation on full blocks and requests padding at end of message.
module keccak_absorb_ctrl
  import keccak_pkg::*;
#(
  parameter int DWIDTH = 256,
  localparam int KEEP_WIDTH = DWIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [RATE_WIDTH-1:0]        rate_i,
  keccak_absorb_ctrl_if.slave          s,
  output logic                         abs_valid_o,
  output logic [DWIDTH-1:0]            abs_msg_o,
  output logic [KEEP_WIDTH-1:0]        abs_keep_o,
  output logic [BYTE_ABSORB_WIDTH-1:0] abs_bytes_o,
  input  logic                         abs_carry_i,
  output logic                         perm_start_o,
  input  logic                         perm_done_i,
  output logic                         pad_en_o,
  output logic [BYTE_ABSORB_WIDTH-1:0] pad_offset_o,
  output logic                         done_o,
  output logic                         busy_o
);

  localparam int SB = STAGE_BYTES * 8;
  localparam int W = BYTE_ABSORB_WIDTH;
  localparam int READY_MAX = STAGE_BYTES - KEEP_WIDTH;

  absorb_state_e state, state_nxt;

  logic [W-1:0]               rate_bytes;
  logic [W-1:0]               cnt;
  logic [W-1:0]               room;
  logic [W-1:0]               take;
  logic [SB-1:0]              stage;
  logic [SB-1:0]              stage_nxt;
  logic [STAGE_CNT_WIDTH-1:0] stage_cnt;
  logic [STAGE_CNT_WIDTH-1:0] stage_cnt_nxt;
  logic [DWIDTH-1:0]          msg;
  logic [KEEP_WIDTH-1:0]      keep;
  logic                       last_seen;
  logic                       pad_sent;
  logic                       in_perm_q;
  logic                       in_absorb;
  logic                       accept;
  logic                       start_ok;

  assign in_absorb = (state == ST_ABSORB);
  assign start_ok  = start_i && rate_legal(rate_i);

  assign s.ready = in_absorb &&
    (stage_cnt <= STAGE_CNT_WIDTH'(READY_MAX)) && !last_seen;
  assign accept = s.valid && s.ready;
  assign room   = rate_bytes - cnt;

  lane_realign #(
    .DWIDTH(DWIDTH)
  ) u_realign (
    .stage         (stage),
    .stage_cnt     (stage_cnt),
    .beat_en       (accept),
    .beat_data     (s.data),
    .beat_keep     (s.keep),
    .room          (room),
    .take          (take),
    .msg           (msg),
    .keep          (keep),
    .stage_nxt     (stage_nxt),
    .stage_cnt_nxt (stage_cnt_nxt)
  );

  assign abs_valid_o = in_absorb && (take != '0);
  assign abs_msg_o   = abs_valid_o ? msg : '0;
  assign abs_keep_o  = abs_valid_o ? keep : '0;
  assign abs_bytes_o = abs_valid_o ? cnt : '0;

  assign perm_start_o = (state == ST_PERM) && !in_perm_q;
  assign pad_en_o     = (state == ST_PAD);
  assign pad_offset_o = pad_en_o ? cnt : '0;
  assign done_o       = (state == ST_DONE);
  assign busy_o       = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_ABSORB;
      end
      ST_ABSORB: begin
        if (cnt == rate_bytes) state_nxt = ST_PERM;
        else if (last_seen && stage_cnt == '0) state_nxt = ST_PAD;
      end
      ST_PERM: begin
        if (perm_done_i) state_nxt = pad_sent ? ST_DONE : ST_ABSORB;
      end
      ST_PAD:  state_nxt = ST_PERM;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_bytes <= '0;
      cnt        <= '0;
      stage      <= '0;
      stage_cnt  <= '0;
      last_seen  <= 1'b0;
      pad_sent   <= 1'b0;
      in_perm_q  <= 1'b0;
    end else begin
      in_perm_q <= (state == ST_PERM);
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            rate_bytes <= rate_i[RATE_WIDTH-1:3];
            cnt        <= '0;
            stage      <= '0;
            stage_cnt  <= '0;
            last_seen  <= 1'b0;
            pad_sent   <= 1'b0;
          end
        end
        ST_ABSORB: begin
          cnt       <= cnt + take;
          stage     <= stage_nxt;
          stage_cnt <= stage_cnt_nxt;
          if (accept && s.last) last_seen <= 1'b1;
        end
        ST_PERM: begin
          if (perm_done_i) cnt <= '0;
        end
        ST_PAD: pad_sent <= 1'b1;
        default: ;
      endcase
    end
  end

  // absorb_unit must never see a beat that crosses the rate boundary
  carry_never: assert property (
    @(posedge clk) disable iff (!rst_n) !abs_carry_i
  );

endmodule
